paddle_pos_gen: RTL



---
 rtl/paddle_pkg.sv | 38 +++
 rtl/paddle_channel.sv | 168 ++++++++++++++++
 rtl/paddle_pos_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/paddle_pkg.sv
// -----------------------------------------------------------------------------
// paddle_pkg
// Shared types, widths and helpers for the paddle position generator.
//   accel_state_t : per-player hold-to-accelerate state
//   POS_W         : width of a paddle position / line-count register
//   CNT_W         : width of the held-frame counter
//   STEP_W        : width of a per-frame step value
//   clamp_pos()   : saturate an 11-bit signed intermediate into [0, max_pos]
// -----------------------------------------------------------------------------
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FAST = 2'd2
    } accel_state_t;

    localparam int POS_W  = 9;
    localparam int CNT_W  = 4;
    localparam int STEP_W = 8;

    // Saturating conversion of a signed intermediate back to a position.
    function automatic logic [POS_W-1:0] clamp_pos(
        input logic signed [10:0] value,
        input logic [POS_W-1:0]   max_pos
    );
        logic [POS_W-1:0] result;
        if (value < 11'sd0) begin
            result = {POS_W{1'b0}};
        end else if (value > $signed({2'b00, max_pos})) begin
            result = max_pos;
        end else begin
            result = value[POS_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// -----------------------------------------------------------------------------
// paddle_channel
// One player's paddle: accel FSM, position register, per-frame line countdown
// and the paddle-timing output.
// Ports:
//   clk_sys, reset      : system clock, synchronous active-low reset
//   i_vs_rise/i_hs_rise : single-cycle frame / line start strobes
//   i_up, i_down        : digital controls
//   i_analog_mode       : 1 = position taken from i_analog (forced 0 when the
//                         PADDLE_ANALOG_EN build option is off)
//   i_analog            : signed two's-complement stick axis
//   i_step_base/fast    : step sizes for normal and accelerated movement
//   o_line_hit          : high while the line countdown sits at zero
//   o_pos               : current position
// -----------------------------------------------------------------------------
module paddle_channel
    import paddle_pkg::*;
#(
    parameter logic [POS_W-1:0] POS_MAX      = 9'd255,
    parameter logic [POS_W-1:0] POS_INIT     = 9'd128,
    parameter logic [CNT_W-1:0] ACCEL_FRAMES = 4'd4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              i_vs_rise,
    input  logic              i_hs_rise,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_analog_mode,
    input  logic [7:0]        i_analog,
    input  logic [STEP_W-1:0] i_step_base,
    input  logic [STEP_W-1:0] i_step_fast,
    output logic              o_line_hit,
    output logic [POS_W-1:0]  o_pos
);

    accel_state_t      r_state;
    accel_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_dir_up;
    logic              w_dir_up_nxt;
    logic [POS_W-1:0]  r_pos;
    logic [POS_W-1:0]  w_pos_nxt;
    logic [POS_W-1:0]  r_cap;
    logic [POS_W-1:0]  w_cap_nxt;

    logic              w_has_dir;
    logic              w_up;
    logic [STEP_W-1:0] w_step;
    logic signed [10:0] w_pos_ext;
    logic signed [10:0] w_step_ext;
    logic signed [10:0] w_sum;
    logic signed [10:0] w_analog_ext;

    // Both or neither control pressed means no direction.
    assign w_has_dir = i_up ^ i_down;
    assign w_up      = i_up & ~i_down;

    // The move uses the state held before this frame's transition, so the
    // first frame of any press always moves by the base step.
    assign w_step     = (r_state == FAST) ? i_step_fast : i_step_base;
    assign w_pos_ext  = $signed({2'b00, r_pos});
    assign w_step_ext = $signed({3'b000, w_step});
    assign w_sum      = w_up ? (w_pos_ext - w_step_ext) : (w_pos_ext + w_step_ext);
    assign w_cnt_inc  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Offset-binary stick mapping: -128 -> 0, 0 -> 128, 127 -> 255.
    assign w_analog_ext = $signed({3'b000, ~i_analog[7], i_analog[6:0]});

    assign o_line_hit = (r_cap == {POS_W{1'b0}});
    assign o_pos      = r_pos;

    // Accel FSM state register.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_dir_up <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_up_nxt;
        end
    end

    // Accel FSM next state, advanced once per frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dir_up_nxt = r_dir_up;
        if (!i_vs_rise) begin
            w_state_nxt = r_state;
        end else if (i_analog_mode || !w_has_dir) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt  = HOLD;
                    w_cnt_nxt    = {{(CNT_W-1){1'b0}}, 1'b1};
                    w_dir_up_nxt = w_up;
                end
                HOLD: begin
                    if (w_up == r_dir_up) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= ACCEL_FRAMES) begin
                            w_state_nxt = FAST;
                        end else begin
                            w_state_nxt = HOLD;
                        end
                    end else begin
                        w_state_nxt  = HOLD;
                        w_cnt_nxt    = {{(CNT_W-1){1'b0}}, 1'b1};
                        w_dir_up_nxt = w_up;
                    end
                end
                FAST: begin
                    if (w_up == r_dir_up) begin
                        w_state_nxt = FAST;
                    end else begin
                        w_state_nxt  = HOLD;
                        w_cnt_nxt    = {{(CNT_W-1){1'b0}}, 1'b1};
                        w_dir_up_nxt = w_up;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Position update and line countdown; a frame start overrides a
    // coincident line start.
    always_comb begin
        w_pos_nxt = r_pos;
        w_cap_nxt = r_cap;
        if (i_vs_rise) begin
            w_cap_nxt = r_pos;
            if (i_analog_mode) begin
                w_pos_nxt = clamp_pos(w_analog_ext, POS_MAX);
            end else if (w_has_dir) begin
                w_pos_nxt = clamp_pos(w_sum, POS_MAX);
            end else begin
                w_pos_nxt = r_pos;
            end
        end else if (i_hs_rise && (r_cap != {POS_W{1'b0}})) begin
            w_cap_nxt = r_cap - {{(POS_W-1){1'b0}}, 1'b1};
        end else begin
            w_cap_nxt = r_cap;
        end
    end

    // Position and countdown registers; reset forces the output high.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_pos <= POS_INIT;
            r_cap <= {POS_W{1'b0}};
        end else begin
            r_pos <= w_pos_nxt;
            r_cap <= w_cap_nxt;
        end
    end

endmodule

// File: rtl/paddle_pos_gen.sv
// -----------------------------------------------------------------------------
// paddle_pos_gen
// Converts player controls into per-line paddle-timing inputs for the chip
// model (pinLPin / pinRPin), emulating the pot/RC charge delay as a line
// countdown from each player's captured position.
// Build option: PADDLE_ANALOG_EN enables analog-stick control via analog_sel;
// without it the analog ports are accepted but ignored.
// Ports:
//   clk_sys, reset        : system clock, synchronous active-low reset
//   hs, vs                : active-high syncs (edge detected internally)
//   speed                 : 1 = STEP_FAST, 0 = STEP_SLOW
//   p1_up .. p2_down      : digital controls
//   p1_analog, p2_analog  : signed stick Y axis
//   analog_sel            : 1 = analog control
//   lp_in, rp_in          : paddle-timing outputs
//   p1_pos, p2_pos        : current positions (debug / OSD)
// -----------------------------------------------------------------------------
module paddle_pos_gen
    import paddle_pkg::*;
#(
    parameter logic [POS_W-1:0]  POS_MAX      = 9'd255,
    parameter logic [POS_W-1:0]  POS_INIT     = 9'd128,
    parameter logic [STEP_W-1:0] STEP_SLOW    = 8'd5,
    parameter logic [STEP_W-1:0] STEP_FAST    = 8'd8,
    parameter logic [CNT_W-1:0]  ACCEL_FRAMES = 4'd4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hs,
    input  logic             vs,
    input  logic             speed,
    input  logic             p1_up,
    input  logic             p1_down,
    input  logic             p2_up,
    input  logic             p2_down,
    input  logic [7:0]       p1_analog,
    input  logic [7:0]       p2_analog,
    input  logic             analog_sel,
    output logic             lp_in,
    output logic             rp_in,
    output logic [POS_W-1:0] p1_pos,
    output logic [POS_W-1:0] p2_pos
);

    logic              r_hs_q;
    logic              r_vs_q;
    logic              w_hs_rise;
    logic              w_vs_rise;
    logic [STEP_W-1:0] w_step_base;
    logic [STEP_W-1:0] w_step_fast;
    logic              w_analog_mode;

    // Sync edge-detect delay registers.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
        end else begin
            r_hs_q <= hs;
            r_vs_q <= vs;
        end
    end

    assign w_hs_rise = hs & ~r_hs_q;
    assign w_vs_rise = vs & ~r_vs_q;

    // Accelerated step is base plus half of base (7 slow, 12 fast).
    assign w_step_base = speed ? STEP_FAST : STEP_SLOW;
    assign w_step_fast = w_step_base + (w_step_base >> 1);

`ifdef PADDLE_ANALOG_EN
    assign w_analog_mode = analog_sel;
`else
    logic w_unused_analog_sel;
    assign w_unused_analog_sel = analog_sel;
    assign w_analog_mode       = 1'b0;
`endif

    paddle_channel #(
        .POS_MAX      (POS_MAX),
        .POS_INIT     (POS_INIT),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_p1 (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .i_vs_rise     (w_vs_rise),
        .i_hs_rise     (w_hs_rise),
        .i_up          (p1_up),
        .i_down        (p1_down),
        .i_analog_mode (w_analog_mode),
        .i_analog      (p1_analog),
        .i_step_base   (w_step_base),
        .i_step_fast   (w_step_fast),
        .o_line_hit    (lp_in),
        .o_pos         (p1_pos)
    );

    paddle_channel #(
        .POS_MAX      (POS_MAX),
        .POS_INIT     (POS_INIT),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_p2 (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .i_vs_rise     (w_vs_rise),
        .i_hs_rise     (w_hs_rise),
        .i_up          (p2_up),
        .i_down        (p2_down),
        .i_analog_mode (w_analog_mode),
        .i_analog      (p2_analog),
        .i_step_base   (w_step_base),
        .i_step_fast   (w_step_fast),
        .o_line_hit    (rp_in),
        .o_pos         (p2_pos)
    );

endmodule
